// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_op_sequencer                                             |
// | Description : Initiator side of the ALU accumulator interface. Replays a   |
// |               stored program of {func, data, expected} entries into the    |
// |               ALU: clears the accumulator, then per entry drives           |
// |               func/data, strobes a load, waits for settle and compares     |
// |               the accumulator with the expected value. Pass/fail tallies   |
// |               and the first failing index are reported.                    |
// | Macro       : ALU_SEQ_STOP_ON_FAIL_EN - when defined, the first mismatch   |
// |               ends the run immediately.                                    |
// | Ports       : clock, reset (async, active-high)                            |
// |               start            - 1-cycle pulse, begins a run (IDLE/DONE)   |
// |               prog_we/addr/wdata - program write port, ignored while busy  |
// |               prog_len         - entries to run, latched at start, clamped |
// |               alu_func/alu_data - operands to the ALU                      |
// |               alu_step/alu_clear - accumulator load / clear strobes        |
// |               alu_result       - registered ALU accumulator               |
// |               busy, done       - run status (done held until next start)  |
// |               pass_cnt, fail_cnt, fail_valid, fail_idx - run results       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_op_sequencer #(
   parameter int DEPTH       = 8,
   parameter int AW          = 3,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [14:0]   prog_wdata,
   input  logic [AW:0]   prog_len,
   output logic [2:0]    alu_func,
   output logic [3:0]    alu_data,
   output logic          alu_step,
   output logic          alu_clear,
   input  logic [7:0]    alu_result,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   pass_cnt,
   output logic [AW:0]   fail_cnt,
   output logic          fail_valid,
   output logic [AW-1:0] fail_idx
);

   localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);
   localparam int          WW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_CHECK = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t          state;
   state_t          next_state;

   logic [14:0]     prog_mem [DEPTH];
   logic [AW:0]     run_len;
   logic [AW:0]     idx;
   logic [AW:0]     idx_next;
   logic [WW-1:0]   wait_cnt;
   logic [14:0]     cur_entry;
   logic            match;
   logic            last_entry;
   logic            start_ok;

   // Program memory has no reset so a stored program survives a board reset.
   always_ff @(posedge clock) begin
      if (prog_we && !busy) begin
         prog_mem[prog_addr] <= prog_wdata;
      end
   end

   // Memory cannot change during a run, so an asynchronous read keeps
   // func/data steady from ISSUE through CHECK without an extra register.
   assign cur_entry  = prog_mem[idx[AW-1:0]];
   assign match      = (alu_result == cur_entry[7:0]);
   assign idx_next   = idx + 1'b1;
   assign last_entry = (idx_next >= run_len);
   assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Outputs are decoded from state so that an asynchronous reset drops
   // the strobes and status immediately.
   always_comb begin
      next_state = state;
      alu_func   = 3'd0;
      alu_data   = 4'd0;
      alu_step   = 1'b0;
      alu_clear  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = S_CLEAR;
            end
         end
         S_CLEAR: begin
            busy      = 1'b1;
            alu_clear = 1'b1;
            next_state = (run_len == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            busy       = 1'b1;
            alu_step   = 1'b1;
            alu_func   = cur_entry[14:12];
            alu_data   = cur_entry[11:8];
            next_state = S_WAIT;
         end
         S_WAIT: begin
            busy     = 1'b1;
            alu_func = cur_entry[14:12];
            alu_data = cur_entry[11:8];
            if (wait_cnt == WAIT_LAST) begin
               next_state = S_CHECK;
            end
         end
         S_CHECK: begin
            busy     = 1'b1;
            alu_func = cur_entry[14:12];
            alu_data = cur_entry[11:8];
`ifdef ALU_SEQ_STOP_ON_FAIL_EN
            next_state = (last_entry || !match) ? S_DONE : S_ISSUE;
`else
            next_state = last_entry ? S_DONE : S_ISSUE;
`endif
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               next_state = S_CLEAR;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run_len    <= '0;
         idx        <= '0;
         wait_cnt   <= '0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         fail_valid <= 1'b0;
         fail_idx   <= '0;
      end else begin
         if (start_ok) begin
            run_len    <= (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
            idx        <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
         end
         if (state == S_ISSUE) begin
            wait_cnt <= '0;
         end
         if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (state == S_CHECK) begin
            idx <= idx_next;
            if (match) begin
               pass_cnt <= pass_cnt + 1'b1;
            end else begin
               fail_cnt <= fail_cnt + 1'b1;
               if (!fail_valid) begin
                  fail_valid <= 1'b1;
                  fail_idx   <= idx[AW-1:0];
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_op_sequencer                                          |
// | Description : Self-checking bench for alu_op_sequencer with a stand-in     |
// |               accumulator ALU and a run-level reference model.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_op_sequencer;

   localparam int DEPTH       = 8;
   localparam int AW          = 3;
   localparam int WAIT_CYCLES = 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [14:0]   prog_wdata = '0;
   logic [AW:0]   prog_len = '0;
   logic [2:0]    alu_func;
   logic [3:0]    alu_data;
   logic          alu_step;
   logic          alu_clear;
   logic [7:0]    alu_result;
   logic          busy;
   logic          done;
   logic [AW:0]   pass_cnt;
   logic [AW:0]   fail_cnt;
   logic          fail_valid;
   logic [AW-1:0] fail_idx;

   int npass  = 0;
   int ncheck = 0;

   always #5 clock = ~clock;

   alu_op_sequencer #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clock(clock), .reset(reset), .start(start),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_len(prog_len),
      .alu_func(alu_func), .alu_data(alu_data), .alu_step(alu_step), .alu_clear(alu_clear),
      .alu_result(alu_result), .busy(busy), .done(done),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_valid(fail_valid), .fail_idx(fail_idx)
   );

   // Stand-in accumulator ALU
   function automatic logic [7:0] alu_f(input logic [2:0] f, input logic [3:0] d, input logic [7:0] a);
      case (f)
         3'd0:    return a + {4'h0, d} + 8'd1;
         3'd1:    return a + {4'h0, d};
         3'd2:    return a - {4'h0, d};
         3'd3:    return {a[3:0], a[3:0]} + {d, 4'h0};
         3'd4:    return a & {4'hF, d};
         3'd5:    return a | {4'h0, d};
         3'd6:    return a ^ {d, d};
         default: return {a[6:0], d[0]};
      endcase
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset)          alu_result <= 8'd0;
      else if (alu_clear) alu_result <= 8'd0;
      else if (alu_step)  alu_result <= alu_f(alu_func, alu_data, alu_result);
   end

   // Strobe monitor
   int   step_total = 0, clear_total = 0, overlap_total = 0, long_total = 0;
   logic prev_step = 1'b0, prev_clear = 1'b0;
   always @(posedge clock) begin
      if (alu_step)                        step_total    <= step_total + 1;
      if (alu_clear)                       clear_total   <= clear_total + 1;
      if (alu_step && alu_clear)           overlap_total <= overlap_total + 1;
      if ((alu_step && prev_step) || (alu_clear && prev_clear)) long_total <= long_total + 1;
      prev_step  <= alu_step;
      prev_clear <= alu_clear;
   end

   // Reference model
   logic [14:0] model_mem [DEPTH];
   int exp_pass, exp_fail, exp_fv, exp_fi, exp_k;

   task automatic model_run(input int len);
      int n;
      logic [7:0] acc;
      n = (len > DEPTH) ? DEPTH : len;
      acc = 8'd0;
      exp_pass = 0; exp_fail = 0; exp_fv = 0; exp_fi = 0; exp_k = n;
      for (int i = 0; i < n; i++) begin
         acc = alu_f(model_mem[i][14:12], model_mem[i][11:8], acc);
         if (acc == model_mem[i][7:0]) begin
            exp_pass++;
         end else begin
            exp_fail++;
            if (exp_fv == 0) begin
               exp_fv = 1;
               exp_fi = i;
            end
`ifdef ALU_SEQ_STOP_ON_FAIL_EN
            exp_k = i + 1;
            break;
`endif
         end
      end
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      ncheck++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic write_entry(input int addr, input logic [2:0] f, input logic [3:0] d, input logic [7:0] e);
      @(negedge clock);
      prog_we    = 1'b1;
      prog_addr  = addr[AW-1:0];
      prog_wdata = {f, d, e};
      @(posedge clock);
      #1 prog_we = 1'b0;
      model_mem[addr] = {f, d, e};
   endtask

   task automatic load_random();
      logic [2:0] f;
      logic [3:0] d;
      logic [7:0] e;
      logic [7:0] acc;
      acc = 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
         f   = 3'($urandom_range(0, 7));
         d   = 4'($urandom);
         acc = alu_f(f, d, acc);
         e   = ($urandom_range(0, 2) != 0) ? acc : 8'($urandom);
         write_entry(i, f, d, e);
      end
   endtask

   task automatic run_and_check(input string tag, input int len, input bit disturb);
      int edges, s0, c0, o0, l0, n;
      model_run(len);
      n  = (len > DEPTH) ? DEPTH : len;
      s0 = step_total; c0 = clear_total; o0 = overlap_total; l0 = long_total;
      @(negedge clock);
      prog_len = len[AW:0];
      start    = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      check({tag, "_busy_rise"}, int'(busy), 1);
      edges = 0;
      while (!done && edges < 400) begin
         @(posedge clock);
         #1 edges++;
         if (disturb && edges == 3) begin
            start      = 1'b1;
            prog_we    = 1'b1;
            prog_addr  = 3'(n - 1);
            prog_wdata = model_mem[n-1] ^ 15'h00FF;
         end else begin
            start   = 1'b0;
            prog_we = 1'b0;
         end
      end
      start   = 1'b0;
      prog_we = 1'b0;
      check({tag, "_done_edges"}, edges, 1 + exp_k * (WAIT_CYCLES + 2));
      check({tag, "_busy_fall"}, int'(busy), 0);
      check({tag, "_pass_cnt"}, int'(pass_cnt), exp_pass);
      check({tag, "_fail_cnt"}, int'(fail_cnt), exp_fail);
      check({tag, "_fail_valid"}, int'(fail_valid), exp_fv);
      check({tag, "_fail_idx"}, int'(fail_idx), exp_fi);
      check({tag, "_steps"}, step_total - s0, exp_k);
      check({tag, "_clears"}, clear_total - c0, 1);
      check({tag, "_overlap"}, overlap_total - o0, 0);
      check({tag, "_pulse_len"}, long_total - l0, 0);
   endtask

   initial begin
      int guard;
      int len;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_step", int'(alu_step), 0);
      check("rst_clear", int'(alu_clear), 0);
      check("rst_pass", int'(pass_cnt), 0);
      check("rst_fail", int'(fail_cnt), 0);
      check("rst_fvalid", int'(fail_valid), 0);
      check("rst_func", int'(alu_func), 0);
      @(negedge clock);
      reset = 1'b0;

      // Directed program: all three entries match
      write_entry(0, 3'b000, 4'h5, 8'h06);
      write_entry(1, 3'b001, 4'h3, 8'h09);
      write_entry(2, 3'b011, 4'h2, 8'hB9);
      run_and_check("t2", 3, 1'b0);

      // Same program, entry 1 wrong
      write_entry(1, 3'b001, 4'h3, 8'h0A);
      run_and_check("t3", 3, 1'b0);

      // Zero length and over-long length
      run_and_check("t4_len0", 0, 1'b0);
      load_random();
      run_and_check("t4_len15", 15, 1'b0);

      // start/prog_we while busy must be ignored
      load_random();
      run_and_check("t5_disturb", 8, 1'b1);
      run_and_check("t5_rerun", 8, 1'b0);

      // Reset in the middle of an ISSUE cycle
      load_random();
      @(negedge clock);
      prog_len = 4'd8;
      start    = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      guard = 0;
      while (!alu_step && guard < 20) begin
         @(posedge clock);
         #1 guard++;
      end
      check("t1_reach_issue", int'(alu_step), 1);
      #2 reset = 1'b1;
      #1;
      check("t1_step", int'(alu_step), 0);
      check("t1_busy", int'(busy), 0);
      check("t1_done", int'(done), 0);
      check("t1_func", int'(alu_func), 0);
      check("t1_data", int'(alu_data), 0);
      check("t1_pass", int'(pass_cnt), 0);
      check("t1_fail", int'(fail_cnt), 0);
      @(negedge clock);
      reset = 1'b0;
      run_and_check("t1_rerun", 8, 1'b0);

      // Random programs and lengths
      for (int r = 0; r < 8; r++) begin
         load_random();
         len = $urandom_range(0, 15);
         run_and_check("rand", len, 1'b0);
      end

      $display("%0d/%0d checks passed", npass, ncheck);
      $finish;
   end

endmodule
`default_nettype wire
